// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing a small register file.
// A frame is R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, all MSB first.
// Writes commit only when nCS rises after exactly FRAME_W SCLK rising edges and the
// address is in range. Reads shift the addressed register out on CIPO.
// No valid/ready handshakes here: pins are sampled through synchronisers and the
// register file is presented as a flat bus with one-cycle commit/error strobes.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic [7:0]                   err_count
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    // Counter must hold FRAME_W + 1, the overrun marker.
    localparam int CW      = $clog2(FRAME_W + 2);

    localparam logic [CW-1:0]     CNT_ADDR   = CW'(ADDR_W);
    localparam logic [CW-1:0]     CNT_HDR    = CW'(1 + ADDR_W);
    localparam logic [CW-1:0]     CNT_FULL   = CW'(FRAME_W);
    localparam logic [CW-1:0]     CNT_OVR    = CW'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   ncs_hist;
    logic                   sclk_hist;
    logic                   ncs_s;
    logic                   sclk_s;
    logic                   copi_s;
    logic                   ncs_fall;
    logic                   ncs_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic [CW-1:0]          cnt;
    logic [FRAME_W-1:0]     shreg;
    logic [FRAME_W-1:0]     next_sh;
    logic                   rw_bit;
    logic                   pend_start;
    logic [DATA_W-1:0]      shadow;
    logic [DATA_W-1:0]      rd_val;
    logic                   read_phase;

    logic                   fr_rw;
    logic [ADDR_W-1:0]      fr_addr;
    logic [DATA_W-1:0]      fr_data;
    logic                   addr_ok;

    logic [DATA_W-1:0]      regs [NUM_REGS];

    // Synchronise the three pins and keep one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync  <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_hist  <= 1'b1;
            sclk_hist <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            ncs_hist  <= ncs_sync[SYNC_STAGES-1];
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_fall  = ncs_hist & ~ncs_s;
    assign ncs_rise  = ~ncs_hist & ncs_s;
    assign sclk_rise = ~sclk_hist & sclk_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    // The driver is enabled for as long as the synchronised chip select is low.
    assign cipo_oe = ~ncs_s;

    assign next_sh    = {shreg[FRAME_W-2:0], copi_s};
    assign read_phase = !rw_bit && (cnt >= CNT_HDR);

    assign fr_rw   = shreg[FRAME_W-1];
    assign fr_addr = shreg[FRAME_W-2 -: ADDR_W];
    assign fr_data = shreg[DATA_W-1:0];
    assign addr_ok = ({1'b0, fr_addr} < NUM_REGS_W);

    // Read-back value for the address completing on this SCLK edge; 0 when out of range.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (next_sh[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // Frame FSM: shifting, read shadow, commit/reject and error accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            rw_bit     <= 1'b0;
            pend_start <= 1'b0;
            shadow     <= '0;
            CIPO       <= 1'b0;
            wr_strobe  <= 1'b0;
            frame_err  <= 1'b0;
            wr_addr    <= '0;
            err_count  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    CIPO <= 1'b0;
                    // A falling nCS wins over any SCLK edge seen in the same cycle.
                    if (ncs_fall || pend_start) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        shreg      <= '0;
                        rw_bit     <= 1'b0;
                        pend_start <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        // An SCLK rise coinciding with nCS rise is deliberately dropped.
                        state <= DONE;
                        CIPO  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            if (cnt != CNT_OVR) begin
                                cnt <= cnt + 1'b1;
                            end
                            if (cnt < CNT_FULL) begin
                                shreg <= next_sh;
                            end
                            if (cnt == '0) begin
                                rw_bit <= copi_s;
                            end
                            // Snapshot the addressed register once the address is complete.
                            if (cnt == CNT_ADDR && !rw_bit) begin
                                shadow <= rd_val;
                            end
                        end
                        if (sclk_fall && read_phase) begin
                            CIPO   <= shadow[DATA_W-1];
                            shadow <= shadow << 1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    CIPO  <= 1'b0;
                    if (ncs_fall) begin
                        pend_start <= 1'b1;
                    end
                    if (cnt == CNT_FULL && fr_rw && addr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (fr_addr == ADDR_W'(i)) begin
                                regs[i] <= fr_data;
                            end
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= fr_addr;
                    end else if (!(cnt == CNT_FULL && !fr_rw)) begin
                        frame_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flatten the register array onto the output bus.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: default instance plus a 16x16-bit instance.
module tb_spi_regfile_peripheral;

    localparam int NR0 = 5;
    localparam int AW0 = 7;
    localparam int DW0 = 8;
    localparam int FW0 = 1 + AW0 + DW0;
    localparam int NR1 = 16;
    localparam int AW1 = 4;
    localparam int DW1 = 16;
    localparam int FW1 = 1 + AW1 + DW1;
    localparam int HALF = 6;
    localparam int GAP  = 10;

    // Clock and reset.
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ncs0 = 1'b1;
    logic ncs1 = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;

    logic                  cipo0, oe0, stb0, err0;
    logic [NR0*DW0-1:0]    flat0;
    logic [AW0-1:0]        wa0;
    logic [7:0]            ec0;
    logic                  cipo1, oe1, stb1, err1;
    logic [NR1*DW1-1:0]    flat1;
    logic [AW1-1:0]        wa1;
    logic [7:0]            ec1;

    spi_regfile_peripheral dut0 (
        .clk(clk), .rst_n(rst_n), .nCS(ncs0), .SCLK(sclk), .COPI(copi),
        .CIPO(cipo0), .cipo_oe(oe0), .regs_flat(flat0), .wr_strobe(stb0),
        .wr_addr(wa0), .frame_err(err0), .err_count(ec0)
    );

    spi_regfile_peripheral #(.NUM_REGS(NR1), .ADDR_W(AW1), .DATA_W(DW1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .nCS(ncs1), .SCLK(sclk), .COPI(copi),
        .CIPO(cipo1), .cipo_oe(oe1), .regs_flat(flat1), .wr_strobe(stb1),
        .wr_addr(wa1), .frame_err(err1), .err_count(ec1)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {kind[1:0], addr[7:0], data[7:0]}; kind 1 = commit, 2 = reject.
    logic [17:0] exp_q[$];
    logic [7:0]  model_regs[NR0];
    int          model_err;
    int          stb1_cnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR0*DW0-1:0] model_flat();
        logic [NR0*DW0-1:0] f;
        f = '0;
        for (int i = 0; i < NR0; i++) f[i*DW0 +: DW0] = model_regs[i];
        return f;
    endfunction

    // Compare process: every cycle, check events and register/error state against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR0; i++) model_regs[i] = 8'h00;
            model_err = 0;
            stb1_cnt  = 0;
        end else begin
            logic [17:0] e;
            if (stb0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
                check("strobe_kind", e[17:16], 2'd1);
                if (e[17:16] == 2'd1 && e[15:8] < NR0) model_regs[e[15:8]] = e[7:0];
                check("wr_addr", wa0, e[15:8]);
            end
            if (err0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
                check("err_kind", e[17:16], 2'd2);
                if (e[17:16] == 2'd2) model_err = (model_err < 255) ? model_err + 1 : 255;
            end
            if (stb1) stb1_cnt++;
            check("regs_flat", flat0, model_flat());
            check("err_count", ec0, model_err);
        end
    end

    // Driver tasks.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [31:0] word, input int k, input int fw);
        if (k < fw) return word[fw-1-k];
        return 1'b0;
    endfunction

    task automatic set_ncs(input int sel, input logic v);
        if (sel == 0) ncs0 = v;
        else ncs1 = v;
    endtask

    task automatic spi_xfer(input int sel, input logic [31:0] word, input int nbits,
                            input int fw, input bit abort, output logic [31:0] rx);
        logic [31:0] r;
        r = '0;
        set_ncs(sel, 1'b0);
        copi = frame_bit(word, 0, fw);
        wait_cyc(HALF);
        check("cipo_oe_active", (sel == 0) ? oe0 : oe1, 1'b1);
        for (int k = 0; k < nbits; k++) begin
            r = {r[30:0], (sel == 0) ? cipo0 : cipo1};
            sclk = 1'b1;
            wait_cyc(HALF);
            sclk = 1'b0;
            copi = frame_bit(word, k + 1, fw);
            wait_cyc(HALF);
        end
        if (abort) begin
            rst_n = 1'b0;
            wait_cyc(2);
            set_ncs(sel, 1'b1);
            wait_cyc(2);
            rst_n = 1'b1;
        end else begin
            set_ncs(sel, 1'b1);
        end
        copi = 1'b0;
        wait_cyc(GAP);
        check("cipo_oe_idle", (sel == 0) ? oe0 : oe1, 1'b0);
        check("cipo_idle", (sel == 0) ? cipo0 : cipo1, 1'b0);
        rx = r;
    endtask

    // Push what the frame must produce, from the frame rules alone.
    task automatic expect_frame(input logic [15:0] word, input int nbits);
        logic       rw;
        logic [6:0] addr;
        rw   = word[15];
        addr = word[14:8];
        if (nbits == FW0 && rw && addr < NR0) exp_q.push_back({2'd1, 1'b0, addr, word[7:0]});
        else if (!(nbits == FW0 && !rw)) exp_q.push_back({2'd2, 16'h0000});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) wait_cyc(1);
        check("event_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send0(input logic [15:0] word, input int nbits, output logic [31:0] rx);
        expect_frame(word, nbits);
        spi_xfer(0, {16'h0, word}, nbits, FW0, 1'b0, rx);
        drain();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        check("rst_regs", flat0, 40'h0);
        check("rst_cipo", cipo0, 1'b0);
        check("rst_oe", oe0, 1'b0);
        check("rst_strobe", stb0, 1'b0);
        check("rst_ferr", err0, 1'b0);
        check("rst_wr_addr", wa0, 7'h0);
        check("rst_err_count", ec0, 8'h0);

        // Write 0xA5 to reg 2, then read it back.
        send0(16'h82A5, 16, rx);
        check("write_a5", flat0, 40'h00_00_A5_00_00);
        check("write_a5_addr", wa0, 7'h02);
        send0(16'h0200, 16, rx);
        check("read_a5", rx[7:0], 8'hA5);
        check("read_a5_hdr", rx[15:8], 8'h00);

        // Short and overrun frames.
        send0(16'h8480, 15, rx);
        check("short_err", ec0, 8'd1);
        send0(16'h8480, 17, rx);
        check("overrun_err", ec0, 8'd2);
        check("no_change", flat0, 40'h00_00_A5_00_00);

        // Out-of-range write and read.
        send0(16'h90FF, 16, rx);
        check("oor_err", ec0, 8'd3);
        send0(16'h1000, 16, rx);
        check("oor_read", rx[7:0], 8'h00);

        // More writes, a read of reg 4, and a short read.
        send0(16'h845A, 16, rx);
        send0(16'h8011, 16, rx);
        check("multi_write", flat0, 40'h5A_00_A5_00_11);
        send0(16'h0400, 16, rx);
        check("read_5a", rx[7:0], 8'h5A);
        send0(16'h0400, 10, rx);
        check("short_read_err", ec0, 8'd4);

        // Reset in the middle of a write frame, then a full write.
        spi_xfer(0, 32'h803C, 9, FW0, 1'b1, rx);
        check("abort_regs", flat0, 40'h0);
        check("abort_err", ec0, 8'd0);
        send0(16'h803C, 16, rx);
        check("after_abort", flat0, 40'h00_00_00_00_3C);
        check("after_abort_err", ec0, 8'd0);

        // Wide instance: 21-bit frame.
        spi_xfer(1, 32'h1FBEEF, FW1, FW1, 1'b0, rx);
        check("w1_strobes", stb1_cnt, 1);
        check("w1_reg15", flat1[255:240], 16'hBEEF);
        check("w1_others", flat1[239:0], 240'h0);
        check("w1_addr", wa1, 4'hF);
        spi_xfer(1, 32'h0F0000, FW1, FW1, 1'b0, rx);
        check("w1_read", rx[15:0], 16'hBEEF);
        check("w1_read_hdr", rx[20:16], 5'h0);
        check("w1_read_nostrobe", stb1_cnt, 1);
        check("w1_no_err", ec1, 8'd0);
        drain();

        // Saturate the error counter with empty frames.
        for (int n = 0; n < 256; n++) send0(16'h0000, 0, rx);
        check("err_saturated", ec0, 8'd255);
        check("regs_kept", flat0, 40'h00_00_00_00_3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
